// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/operand stage: opcodes, stage states and
// instruction field offsets.
package pipe_pkg;

    localparam logic [3:0] OP_LOAD  = 4'hF;
    localparam logic [3:0] OP_STORE = 4'hE;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    function automatic int instr_width(input int reg_aw);
        return 4 + 3 * reg_aw;
    endfunction

    function automatic int addr_width(input int reg_aw);
        return 2 * reg_aw;
    endfunction

    // Field A: ALU dest, and the low end of the LOAD/STORE address.
    function automatic int field_a_lo(input int reg_aw);
        return 4 + 0 * reg_aw;
    endfunction

    // Field B: ALU src1.
    function automatic int field_b_lo(input int reg_aw);
        return 4 + reg_aw;
    endfunction

    // Field C: ALU src2, LOAD dest, STORE data source.
    function automatic int field_c_lo(input int reg_aw);
        return 4 + 2 * reg_aw;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Pure combinational field extraction and operand need-masks for one instruction.
// Sources that the opcode does not read are presented as index 0.
module instr_field_decode
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter int INSTR_W = 4 + 3 * REG_AW,
    parameter int ADDR_W  = 2 * REG_AW
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [REG_AW-1:0]  dest,
    output logic [REG_AW-1:0]  src1,
    output logic [REG_AW-1:0]  src2,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               need1,
    output logic               need2,
    output logic               has_dest
);

    localparam int LO_A = field_a_lo(REG_AW);
    localparam int LO_B = field_b_lo(REG_AW);
    localparam int LO_C = field_c_lo(REG_AW);

    logic [REG_AW-1:0] fld_a;
    logic [REG_AW-1:0] fld_b;
    logic [REG_AW-1:0] fld_c;
    logic [ADDR_W-1:0] fld_addr;

    assign fld_a    = instr[LO_A +: REG_AW];
    assign fld_b    = instr[LO_B +: REG_AW];
    assign fld_c    = instr[LO_C +: REG_AW];
    assign fld_addr = instr[LO_A +: ADDR_W];

    always_comb begin
        opcode   = instr[3:0];
        dest     = '0;
        src1     = '0;
        src2     = '0;
        mem_addr = '0;
        need1    = 1'b0;
        need2    = 1'b0;
        has_dest = 1'b0;
        case (instr[3:0])
            OP_LOAD: begin
                mem_addr = fld_addr;
                dest     = fld_c;
                has_dest = 1'b1;
            end
            OP_STORE: begin
                mem_addr = fld_addr;
                src1     = fld_c;
                need1    = 1'b1;
            end
            default: begin
                dest     = fld_a;
                src1     = fld_b;
                src2     = fld_c;
                need1    = 1'b1;
                need2    = 1'b1;
                has_dest = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode/operand-fetch stage: holds one instruction, waits for its sources to
// be free, then presents the decoded payload. Write-back bypass: DECODE_BYPASS_EN.
module decode_operand_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    localparam int INSTR_W = instr_width(REG_AW),
    localparam int ADDR_W  = addr_width(REG_AW)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_AW-1:0]  src_reg1,
    output logic [REG_AW-1:0]  src_reg2,
    input  logic [DATA_W-1:0]  src_val1,
    input  logic [DATA_W-1:0]  src_val2,
    input  logic               inuse1,
    input  logic               inuse2,
    output logic               claim_valid,
    output logic [REG_AW-1:0]  claim_reg,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         opcode,
    output logic [REG_AW-1:0]  dest_reg,
    output logic [DATA_W-1:0]  op_val1,
    output logic [DATA_W-1:0]  op_val2,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               flush,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_reg,
    input  logic [DATA_W-1:0]  wb_val
);

    stage_state_t       state_reg;
    logic               rst_done_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [3:0]         opcode_reg;
    logic [REG_AW-1:0]  dest_out_reg;
    logic [DATA_W-1:0]  val1_reg;
    logic [DATA_W-1:0]  val2_reg;
    logic [ADDR_W-1:0]  addr_reg;

    logic [3:0]         dec_opcode;
    logic [REG_AW-1:0]  dec_dest;
    logic [REG_AW-1:0]  dec_src1;
    logic [REG_AW-1:0]  dec_src2;
    logic [ADDR_W-1:0]  dec_addr;
    logic               dec_need1;
    logic               dec_need2;
    logic               dec_has_dest;

    instr_field_decode #(
        .REG_AW  (REG_AW),
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_decode (
        .instr    (instr_reg),
        .opcode   (dec_opcode),
        .dest     (dec_dest),
        .src1     (dec_src1),
        .src2     (dec_src2),
        .mem_addr (dec_addr),
        .need1    (dec_need1),
        .need2    (dec_need2),
        .has_dest (dec_has_dest)
    );

    assign src_reg1 = dec_src1;
    assign src_reg2 = dec_src2;

    // Identical sources form one dependency: lane 1 mirrors lane 0's read port.
    logic               same_src;
    logic [1:0]         need;
    logic [1:0]         lane_inuse;
    logic [1:0]         blocked;
    logic [DATA_W-1:0]  lane_val [2];
    logic [DATA_W-1:0]  opnd_val [2];

    assign need          = {dec_need2, dec_need1};
    assign same_src      = dec_need1 && dec_need2 && (dec_src1 == dec_src2);
    assign lane_inuse[0] = inuse1;
    assign lane_inuse[1] = same_src ? inuse1 : inuse2;
    assign lane_val[0]   = src_val1;
    assign lane_val[1]   = same_src ? src_val1 : src_val2;

`ifdef DECODE_BYPASS_EN
    logic [REG_AW-1:0] src_idx [2];
    assign src_idx[0] = dec_src1;
    assign src_idx[1] = dec_src2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_reg, wb_val};
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
`ifdef DECODE_BYPASS_EN
            logic wb_hit;
            assign wb_hit        = wb_valid && (wb_reg == src_idx[gi]);
            assign blocked[gi]   = need[gi] & lane_inuse[gi] & ~wb_hit;
            assign opnd_val[gi]  = need[gi] ? (wb_hit ? wb_val : lane_val[gi]) : '0;
`else
            assign blocked[gi]   = need[gi] & lane_inuse[gi];
            assign opnd_val[gi]  = need[gi] ? lane_val[gi] : '0;
`endif
        end
    endgenerate

    logic operands_ready;
    logic accept;

    assign operands_ready = (state_reg == ST_WAIT) && (blocked == 2'b00);
    assign in_ready       = rst_done_reg &&
                            ((state_reg == ST_EMPTY) || ((state_reg == ST_FULL) && out_ready));
    assign accept         = in_valid && in_ready;

    // The claim goes out in the same cycle the operands are read, so the
    // scoreboard marks the destination busy as the instruction leaves WAIT.
    assign claim_valid = operands_ready && dec_has_dest && !flush;
    assign claim_reg   = claim_valid ? dec_dest : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_EMPTY;
            rst_done_reg <= 1'b0;
            instr_reg    <= '0;
            opcode_reg   <= '0;
            dest_out_reg <= '0;
            val1_reg     <= '0;
            val2_reg     <= '0;
            addr_reg     <= '0;
        end else begin
            rst_done_reg <= 1'b1;
            if (flush) begin
                state_reg <= ST_EMPTY;
                instr_reg <= '0;
            end else begin
                case (state_reg)
                    ST_EMPTY: begin
                        if (accept) begin
                            state_reg <= ST_WAIT;
                            instr_reg <= instr;
                        end
                    end
                    ST_WAIT: begin
                        if (operands_ready) begin
                            state_reg    <= ST_FULL;
                            opcode_reg   <= dec_opcode;
                            dest_out_reg <= dec_dest;
                            val1_reg     <= opnd_val[0];
                            val2_reg     <= opnd_val[1];
                            addr_reg     <= dec_addr;
                        end
                    end
                    ST_FULL: begin
                        if (out_ready) begin
                            if (accept) begin
                                state_reg <= ST_WAIT;
                                instr_reg <= instr;
                            end else begin
                                state_reg <= ST_EMPTY;
                            end
                        end
                    end
                    default: state_reg <= ST_EMPTY;
                endcase
            end
        end
    end

    assign out_valid = (state_reg == ST_FULL);
    assign opcode    = opcode_reg;
    assign dest_reg  = dest_out_reg;
    assign op_val1   = val1_reg;
    assign op_val2   = val2_reg;
    assign mem_addr  = addr_reg;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Scoreboard bench for decode_operand_stage: directed scenarios plus random
// traffic checked against a field-rule reference model.
module tb_decode_operand_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  dest;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [7:0]  addr;
    } pkt_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [3:0]  src_reg1, src_reg2;
    logic [15:0] src_val1, src_val2;
    logic        inuse1, inuse2;
    logic        claim_valid;
    logic [3:0]  claim_reg;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [3:0]  dest_reg;
    logic [15:0] op_val1, op_val2;
    logic [7:0]  mem_addr;
    logic        flush;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [15:0] wb_val;

    // Environment: register file contents, busy bits, and noise on read port 2
    // whenever both ports address the same register.
    logic [15:0] regfile [16];
    logic [15:0] busy;
    logic        force_inuse;
    logic        noise;
    logic        wb_model_on;
    logic [3:0]  wb_model_reg;
    logic [15:0] wb_model_val;

    int n_checks;
    int n_fail;
    int n_txn;
    pkt_t exp_q[$];
    logic [3:0] claim_q[$];

    decode_operand_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .src_reg1    (src_reg1),
        .src_reg2    (src_reg2),
        .src_val1    (src_val1),
        .src_val2    (src_val2),
        .inuse1      (inuse1),
        .inuse2      (inuse2),
        .claim_valid (claim_valid),
        .claim_reg   (claim_reg),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode      (opcode),
        .dest_reg    (dest_reg),
        .op_val1     (op_val1),
        .op_val2     (op_val2),
        .mem_addr    (mem_addr),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_val      (wb_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign src_val1 = regfile[src_reg1];
    assign src_val2 = (src_reg1 == src_reg2) ? ~regfile[src_reg2] : regfile[src_reg2];
    assign inuse1   = force_inuse | busy[src_reg1];
    assign inuse2   = force_inuse | ((src_reg1 == src_reg2) ? noise : busy[src_reg2]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rf_val(input int r);
        if (wb_model_on && r == int'(wb_model_reg))
            return wb_model_val;
        return regfile[r];
    endfunction

    // Reference: apply the opcode's field rules with plain integer arithmetic.
    function automatic pkt_t model(input logic [15:0] ins);
        pkt_t p;
        int w, code, fa, fb, fc;
        w    = int'(ins);
        code = w % 16;
        fa   = (w / 16) % 16;
        fb   = (w / 256) % 16;
        fc   = w / 4096;
        p    = '0;
        p.op = 4'(code);
        if (code == 15) begin
            p.addr = 8'((w / 16) % 256);
            p.dest = 4'(fc);
        end else if (code == 14) begin
            p.addr = 8'((w / 16) % 256);
            p.v1   = rf_val(fc);
        end else begin
            p.dest = 4'(fa);
            p.v1   = rf_val(fb);
            p.v2   = rf_val(fc);
        end
        return p;
    endfunction

    function automatic pkt_t cur_payload();
        return {opcode, dest_reg, op_val1, op_val2, mem_addr};
    endfunction

    // Stimulus-side: an accept will happen at the coming edge.
    always @(negedge clk) begin : pusher
        pkt_t p;
        if (rst && in_valid && in_ready && !flush) begin
            p = model(instr);
            exp_q.push_back(p);
            if (p.op != 4'hE)
                claim_q.push_back(p.dest);
        end
    end

    always @(negedge clk) begin : out_monitor
        pkt_t e;
        pkt_t a;
        if (rst && out_valid && out_ready && !flush) begin
            a = cur_payload();
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_out: got %h expected none", a);
            end else begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d op=%h dest=%h v1=%h v2=%h addr=%h (exp %h)",
                         n_txn, a.op, a.dest, a.v1, a.v2, a.addr, e);
                chk("sb_payload", 64'(a), 64'(e));
            end
        end
    end

    always @(negedge clk) begin : claim_monitor
        logic [3:0] e;
        if (rst && claim_valid) begin
            if (claim_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_claim: got %h expected none", claim_reg);
            end else begin
                e = claim_q.pop_front();
                chk("sb_claim_reg", 64'(claim_reg), 64'(e));
            end
        end
    end

    always @(negedge clk) begin : hold_monitor
        static logic hold_prev = 1'b0;
        static pkt_t snap_prev = '0;
        if (hold_prev && rst)
            chk("hold_stable", 64'({out_valid, cur_payload()}), 64'({1'b1, snap_prev}));
        hold_prev = rst && out_valid && !out_ready && !flush;
        snap_prev = cur_payload();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        busy        = '0;
        force_inuse = 1'b0;
        noise       = 1'b0;
        flush       = 1'b0;
        wb_valid    = 1'b0;
        repeat (4) step();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_claim_valid"}, 64'(claim_valid), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_payload"}, 64'(cur_payload()), 64'(0));
        chk({tag, "_src_regs"}, 64'({src_reg1, src_reg2, claim_reg}), 64'(0));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        pkt_t e;
        n_checks = 0; n_fail = 0; n_txn = 0;
        rst = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1; flush = 1'b0;
        wb_valid = 1'b0; wb_reg = '0; wb_val = '0; busy = '0;
        force_inuse = 1'b0; noise = 1'b0;
        wb_model_on = 1'b0; wb_model_reg = '0; wb_model_val = '0;
        for (int i = 0; i < 16; i++) regfile[i] = 16'($urandom);

        repeat (2) @(negedge clk);
        check_reset("init");
        step();
        rst = 1'b1;
        @(negedge clk); chk("rst_rel_ready_low", 64'(in_ready), 64'(0));
        @(negedge clk); chk("rst_rel_ready_high", 64'(in_ready), 64'(1));

        // ALU, free operands
        settle();
        regfile[5] = 16'h0011; regfile[6] = 16'h0022;
        in_valid = 1'b1; instr = 16'h6531;
        @(negedge clk); chk("alu_in_ready", 64'(in_ready), 64'(1));
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("alu_wait_out_valid", 64'(out_valid), 64'(0));
        chk("alu_claim", 64'({claim_valid, claim_reg}), 64'({1'b1, 4'd3}));
        step();
        @(negedge clk);
        chk("alu_out_valid", 64'(out_valid), 64'(1));
        chk("alu_vals", 64'({op_val1, op_val2, dest_reg}), 64'({16'h0011, 16'h0022, 4'd3}));
        chk("alu_claim_done", 64'(claim_valid), 64'(0));
        step();
        @(negedge clk); chk("alu_drained", 64'(out_valid), 64'(0));

        // LOAD ignores inuse
        settle();
        force_inuse = 1'b1; in_valid = 1'b1; instr = 16'h7A5F;
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("load_claim", 64'({claim_valid, claim_reg}), 64'({1'b1, 4'd7}));
        step();
        @(negedge clk);
        chk("load_out_valid", 64'(out_valid), 64'(1));
        chk("load_payload", 64'({mem_addr, dest_reg, op_val1, op_val2}),
            64'({8'hA5, 4'd7, 16'h0, 16'h0}));

        // ALU stalled on src2, then held at the output
        settle();
        busy[9] = 1'b1; in_valid = 1'b1; instr = 16'h9243;
        step(); instr = 16'h0C75;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'(0));
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_no_claim", 64'(claim_valid), 64'(0));
            step();
        end
        busy = '0; out_ready = 1'b0;
        @(negedge clk);
        chk("stall_claim", 64'({claim_valid, claim_reg}), 64'({1'b1, 4'd4}));
        step();
        e = model(16'h9243);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_payload", 64'(cur_payload()), 64'(e));
            step();
        end
        out_ready = 1'b1;
        @(negedge clk); chk("b2b_in_ready", 64'(in_ready), 64'(1));
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_wait", 64'(out_valid), 64'(0));
        chk("b2b_claim", 64'({claim_valid, claim_reg}), 64'({1'b1, 4'd7}));
        step();
        @(negedge clk); chk("b2b_out_valid", 64'(out_valid), 64'(1));

        // Flush during WAIT, then flush against an accept in EMPTY
        settle();
        busy[2] = 1'b1; in_valid = 1'b1; instr = 16'h9243;
        step(); in_valid = 1'b0;
        @(negedge clk); chk("fl_stalled", 64'(claim_valid), 64'(0));
        step();
        flush = 1'b1; busy = '0; in_valid = 1'b1; instr = 16'h0C75;
        exp_q.delete(); claim_q.delete();
        @(negedge clk); chk("fl_claim_suppressed", 64'(claim_valid), 64'(0));
        step(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_empty_out", 64'(out_valid), 64'(0));
        chk("fl_empty_ready", 64'(in_ready), 64'(1));
        flush = 1'b1; in_valid = 1'b1;
        step(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_accept_dropped", 64'({out_valid, claim_valid, in_ready}), 64'(3'b001));
        step();
        @(negedge clk); chk("fl_still_empty", 64'({out_valid, claim_valid}), 64'(0));

        // Reset during WAIT
        settle();
        busy[2] = 1'b1; in_valid = 1'b1; instr = 16'h9243;
        step(); in_valid = 1'b0;
        step();
        rst = 1'b0; busy = '0;
        exp_q.delete(); claim_q.delete();
        #1 check_reset("rst_mid");
        step(); step();
        rst = 1'b1;
        @(negedge clk); chk("rst_mid_ready_low", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("rst_mid_ready_high", 64'(in_ready), 64'(1));
        chk("rst_mid_dropped", 64'({out_valid, claim_valid}), 64'(0));
        step();
        @(negedge clk); chk("rst_mid_idle", 64'({out_valid, claim_valid}), 64'(0));

`ifdef DECODE_BYPASS_EN
        settle();
        regfile[8] = 16'h1234; busy[8] = 1'b1;
        wb_valid = 1'b1; wb_reg = 4'd8; wb_val = 16'hBEEF;
        wb_model_on = 1'b1; wb_model_reg = 4'd8; wb_model_val = 16'hBEEF;
        in_valid = 1'b1; instr = 16'hA811;
        step(); in_valid = 1'b0;
        @(negedge clk); chk("byp_claim", 64'({claim_valid, claim_reg}), 64'({1'b1, 4'd1}));
        step();
        @(negedge clk);
        chk("byp_out_valid", 64'(out_valid), 64'(1));
        chk("byp_val1", 64'(op_val1), 64'(16'hBEEF));
        step();
        wb_model_on = 1'b0;
`endif

        // Random traffic
        settle();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 10) < 6;
            instr     = 16'($urandom);
            out_ready = ($urandom % 10) < 7;
            busy      = 16'($urandom & $urandom);
            noise     = 1'($urandom);
`ifdef DECODE_BYPASS_EN
            wb_valid  = 1'b0;
`else
            wb_valid  = 1'($urandom);
            wb_reg    = 4'($urandom);
            wb_val    = 16'($urandom);
`endif
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; busy = '0; wb_valid = 1'b0;
        repeat (10) step();
        chk("sb_drained_out", 64'(exp_q.size()), 64'(0));
        chk("sb_drained_claim", 64'(claim_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_operand_stage.md
DECODE_OPERAND_STAGE -- requirements
Module: decode_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register/operand data width.
REQ-002 SHALL have parameter REG_AW, default 4, meaning register index width; derived INSTR_W = 4+3*REG_AW, ADDR_W = 2*REG_AW.
REQ-003 SHALL have port clk, input, 1, meaning single clock; all state on posedge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-low (asserted at 0).
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, instr input INSTR_W, meaning fetch-side handshake and instruction.
REQ-006 SHALL have ports src_reg1, src_reg2 output REG_AW, src_val1, src_val2 input DATA_W, inuse1, inuse2 input 1, meaning register-file read and scoreboard.
REQ-007 SHALL have ports claim_valid output 1, claim_reg output REG_AW, meaning destination-claim request to the register-file scoreboard.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, opcode output 4, dest_reg output REG_AW, op_val1, op_val2 output DATA_W, mem_addr output ADDR_W, meaning execute-side handshake and payload.
REQ-009 SHALL have port flush, input, 1, meaning synchronous pipeline flush.
REQ-010 SHALL have ports wb_valid input 1, wb_reg input REG_AW, wb_val input DATA_W, meaning write-back bypass source; ignored unless DECODE_BYPASS_EN.

Function
REQ-011 SHALL decode opcode = instr[3:0]; LOAD = 4'hF, STORE = 4'hE, all others ALU.
REQ-012 SHALL decode ALU: dest = instr[4+:REG_AW], src1 = instr[4+REG_AW+:REG_AW], src2 = instr[4+2*REG_AW+:REG_AW]; both sources needed.
REQ-013 SHALL decode LOAD: mem_addr = instr[4+:ADDR_W], dest = instr[4+ADDR_W+:REG_AW]; no source needed.
REQ-014 SHALL decode STORE: mem_addr as LOAD, src1 = instr[4+ADDR_W+:REG_AW]; no destination, no claim.
REQ-015 SHALL implement FSM EMPTY, WAIT, FULL: EMPTY -> WAIT on accept; WAIT -> FULL when no needed operand is in use; FULL -> WAIT on out_ready with new accept, FULL -> EMPTY on out_ready without accept.
REQ-016 SHALL drive in_ready = (state==EMPTY) | (state==FULL & out_ready); accept = in_valid & in_ready.
REQ-017 SHALL drive src_reg1/src_reg2 from the held instruction; unneeded sources read as 0 and their inuse is masked.
REQ-018 SHALL, on WAIT->FULL, register opcode, dest_reg, mem_addr, op_val1, op_val2 (unneeded value = 0) and pulse claim_valid/claim_reg for that one cycle (non-STORE only).
REQ-019 SHALL give latency: accept at edge N -> out_valid high after edge N+1 when operands free; each stalled cycle adds one.
REQ-020 SHALL hold all output payload stable while out_valid & ~out_ready.
REQ-021 SHALL treat src1==src2 as a single dependency; both values taken from the same read.
REQ-022 SHALL, on flush, go to EMPTY at the next edge, drop held and output instructions, suppress claim_valid; flush wins over simultaneous accept and WAIT->FULL.

Reset
REQ-023 SHALL, while rst==0, force state EMPTY, out_valid 0, claim_valid 0, in_ready 0, and opcode, dest_reg, op_val1, op_val2, mem_addr, src_reg1, src_reg2, claim_reg all 0.
REQ-024 SHALL discard any in-flight instruction on reset mid-operation; in_ready rises the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with DECODE_BYPASS_EN defined, treat a needed operand whose index equals wb_reg while wb_valid as not in use and capture wb_val for it.
REQ-026 SHALL, without DECODE_BYPASS_EN, ignore wb_* entirely; stalls resolve only via inuse.

Structure
REQ-027 SHALL place opcode constants (OP_LOAD, OP_STORE), FSM state encoding and field-offset functions in shared package pipe_pkg.
REQ-028 SHALL factor field extraction and need-masks into combinational sub-module instr_field_decode; FSM and registers stay in the top.

Verification
REQ-029 SHALL cover ALU 4'h1 dest 3 src 5,6, inuse 0, vals 16'h0011/16'h0022 -> out_valid 2 cycles after in_valid, op_val1=16'h0011, op_val2=16'h0022, claim_reg=3 pulse.
REQ-030 SHALL cover LOAD addr 8'hA5 dest 7 with inuse1=inuse2=1 -> no stall, mem_addr=8'hA5, dest_reg=7, op_vals 0.
REQ-031 SHALL cover ALU with inuse2 high 3 cycles -> state WAIT 3 cycles, in_ready 0, then FULL; no claim until then.
REQ-032 SHALL cover out_ready low 4 cycles while FULL -> payload stable, in_ready 0; back-to-back accept when out_ready returns.
REQ-033 SHALL cover flush and rst low during WAIT -> EMPTY, out_valid 0, no claim_valid.
REQ-034 SHALL cover bypass with macro defined: inuse1=1, wb_valid=1, wb_reg=src1, wb_val=16'hBEEF -> no stall, op_val1=16'hBEEF.
